// File: rtl/step_arbiter_pkg.sv
// Shared definitions for the step arbiter: FSM state encoding and default sizing.
// The GAP encoding exists only when STEP_ARB_GAP_EN is defined.
package step_arb_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int LEN_W_DEF   = 4;

`ifdef STEP_ARB_GAP_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_GAP   = 2'b10,
      ST_DONE  = 2'b11
   } arb_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_DONE  = 2'b11
   } arb_state_e;
`endif

endpackage

// File: rtl/step_arbiter_if.sv
// Requester-side bundle of the step arbiter.
// The master modport is the requester side and the slave modport is the arbiter.
interface step_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 4
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*LEN_W-1:0] req_len;
   logic [NUM_REQ-1:0]       gnt;
   logic [NUM_REQ-1:0]       done;
   logic                     step_out;
   logic                     busy;

   modport master (
      output req,
      output req_len,
      input  gnt,
      input  done,
      input  step_out,
      input  busy
   );

   modport slave (
      input  req,
      input  req_len,
      output gnt,
      output done,
      output step_out,
      output busy
   );
endinterface

// File: rtl/step_arbiter_rr_pick.sv
// Combinational round-robin selector: the first asserted request scanning
// upward from ptr+1, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IDX_W-1:0]   pick_idx,
   output logic               any
);

   localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   // scan the requests in priority order starting just after the last winner
   always_comb begin
      logic found_s;
      int   idx_s;
      found_s  = 1'b0;
      idx_s    = 0;
      pick_idx = '0;
      any      = |req;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_s = (int'(ptr) + k) % NUM_REQ;
         if (!found_s && req[idx_s]) begin
            found_s  = 1'b1;
            pick_idx = IDX_W'(idx_s);
         end else begin
            found_s  = found_s;
         end
      end
      if (any) begin
         pick = ONE_HOT_0 << pick_idx;
      end else begin
         pick = '0;
      end
   end

endmodule

// File: rtl/step_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst of step pulses.
// Define STEP_ARB_GAP_EN to insert one low cycle between consecutive pulses.
module step_arbiter
   import step_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int LEN_W   = LEN_W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   step_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
   localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0]   PTR_INIT  = IDX_W'(NUM_REQ - 1);

   arb_state_e         state_r, state_s;
   logic [LEN_W-1:0]   cnt_r, cnt_s;
   logic [IDX_W-1:0]   ptr_r, ptr_s;
   logic [IDX_W-1:0]   win_r, win_s;
   logic [NUM_REQ-1:0] gnt_r, gnt_s;
   logic [NUM_REQ-1:0] done_r, done_s;
   logic               step_r, step_s;
   logic               busy_r, busy_s;

   logic [NUM_REQ-1:0] pick_s;
   logic [IDX_W-1:0]   pick_idx_s;
   logic               any_s;
   logic [LEN_W-1:0]   len_s;
   logic [NUM_REQ-1:0] win_onehot_s;

   rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
      .req      (bus.req),
      .ptr      (ptr_r),
      .pick     (pick_s),
      .pick_idx (pick_idx_s),
      .any      (any_s)
   );

   assign len_s        = bus.req_len[pick_idx_s*LEN_W +: LEN_W];
   assign win_onehot_s = ONE_HOT_0 << win_r;

   // next-state and next-output logic; outputs are registered below
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      ptr_s   = ptr_r;
      win_s   = win_r;
      gnt_s   = gnt_r;
      done_s  = '0;
      step_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            gnt_s = '0;
            if (any_s) begin
               win_s = pick_idx_s;
               gnt_s = pick_s;
               cnt_s = len_s;
               if (len_s == '0) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_ISSUE;
                  step_s  = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_s = cnt_r - LEN_ONE;
            if (cnt_r == LEN_ONE) begin
               state_s = ST_DONE;
               done_s  = win_onehot_s;
               gnt_s   = '0;
            end else begin
`ifdef STEP_ARB_GAP_EN
               state_s = ST_GAP;
               step_s  = 1'b0;
`else
               state_s = ST_ISSUE;
               step_s  = 1'b1;
`endif
            end
         end
`ifdef STEP_ARB_GAP_EN
         ST_GAP: begin
            state_s = ST_ISSUE;
            step_s  = 1'b1;
         end
`endif
         ST_DONE: begin
            gnt_s = '0;
            // a zero-length grant enters DONE with gnt still up; done follows one cycle later
            if (done_r != '0) begin
               state_s = ST_IDLE;
               ptr_s   = win_r;
            end else begin
               state_s = ST_DONE;
               done_s  = win_onehot_s;
            end
         end
         default: begin
            state_s = ST_IDLE;
            gnt_s   = '0;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // state, counter, pointer and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         ptr_r   <= PTR_INIT;
         win_r   <= '0;
         gnt_r   <= '0;
         done_r  <= '0;
         step_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         ptr_r   <= ptr_s;
         win_r   <= win_s;
         gnt_r   <= gnt_s;
         done_r  <= done_s;
         step_r  <= step_s;
         busy_r  <= busy_s;
      end
   end

   assign bus.gnt      = gnt_r;
   assign bus.done     = done_r;
   assign bus.step_out = step_r;
   assign bus.busy     = busy_r;

endmodule

// File: tb/tb_step_arbiter.sv
// Randomized bench for step_arbiter against a transaction-level schedule model.
// Honours STEP_ARB_GAP_EN in the model when the design is built with it.
module tb_step_arbiter;
   import step_arb_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int LEN_W   = 4;

   typedef struct packed {
      logic [NUM_REQ-1:0] gnt;
      logic [NUM_REQ-1:0] done;
      logic               step;
      logic               busy;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_ptr;
   exp_t exp_q[$];

   step_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus_if ();

   step_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   // Expected output sequence of one grant, from the winner onward
   task automatic plan(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*LEN_W-1:0] l);
      int   w = 0;
      bit   found = 0;
      int   len;
      logic [NUM_REQ-1:0] oh;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int c = (m_ptr + k) % NUM_REQ;
         if (!found && r[c]) begin
            w = c;
            found = 1;
         end
      end
      len   = int'(l[w*LEN_W +: LEN_W]);
      m_ptr = w;
      oh    = NUM_REQ'(1) << w;
      if (len == 0) begin
         exp_q.push_back('{gnt: oh, done: '0, step: 1'b0, busy: 1'b1});
      end else begin
         for (int k = 1; k <= len; k++) begin
            exp_q.push_back('{gnt: oh, done: '0, step: 1'b1, busy: 1'b1});
`ifdef STEP_ARB_GAP_EN
            if (k < len) exp_q.push_back('{gnt: oh, done: '0, step: 1'b0, busy: 1'b1});
`endif
         end
      end
      exp_q.push_back('{gnt: '0, done: oh, step: 1'b0, busy: 1'b1});
   endtask

   // Check this cycle's outputs, then drive the inputs the next edge will see
   task automatic cycle(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*LEN_W-1:0] l);
      exp_t e;
      bit   idle;
      idle = (exp_q.size() == 0);
      if (idle) e = '0;
      else      e = exp_q.pop_front();
      check_eq("gnt",      32'(bus_if.gnt),      32'(e.gnt));
      check_eq("done",     32'(bus_if.done),     32'(e.done));
      check_eq("step_out", 32'(bus_if.step_out), 32'(e.step));
      check_eq("busy",     32'(bus_if.busy),     32'(e.busy));
      bus_if.req     = r;
      bus_if.req_len = l;
      if (idle && r != '0) plan(r, l);
      @(negedge clk);
   endtask

   task automatic reset_now();
      reset = 1'b1;
      #1;
      check_eq("rst_gnt",  32'(bus_if.gnt),      32'd0);
      check_eq("rst_done", 32'(bus_if.done),     32'd0);
      check_eq("rst_step", 32'(bus_if.step_out), 32'd0);
      check_eq("rst_busy", 32'(bus_if.busy),     32'd0);
      exp_q.delete();
      m_ptr = NUM_REQ - 1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bus_if.req     = '0;
      bus_if.req_len = '0;
      reset_now();

      // single request, length 3
      cycle(4'b0001, 16'h0003);
      repeat (6) cycle(4'b0000, 16'h0000);

      // all requesting, length 1: order 0,1,2,3,0...
      repeat (16) cycle(4'b1111, 16'h1111);
      repeat (4) cycle(4'b0000, 16'h0000);

      // zero-length burst on requester 2
      cycle(4'b0100, 16'h0000);
      repeat (4) cycle(4'b0000, 16'h0000);

      // req dropped and length changed during a length-5 burst
      cycle(4'b0010, 16'h0050);
      repeat (12) cycle(4'b0000, 16'h1111);

      // asynchronous reset in the middle of a burst
      cycle(4'b1000, 16'hF000);
      repeat (3) cycle(4'b0000, 16'h0000);
      check_eq("busy_before_rst", 32'(bus_if.busy), 32'd1);
      reset_now();
      repeat (10) cycle(4'b1111, 16'h2222);
      repeat (4) cycle(4'b0000, 16'h0000);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [NUM_REQ-1:0]       r;
         logic [NUM_REQ*LEN_W-1:0] l;
         r = ($urandom_range(0, 1) == 0) ? NUM_REQ'($urandom) : '0;
         l = (NUM_REQ*LEN_W)'($urandom);
         cycle(r, l);
      end

      for (int i = 0; i < 100 && exp_q.size() > 0; i++) cycle(4'b0000, 16'h0000);
      cycle(4'b0000, 16'h0000);
      check_eq("drain", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/step_arbiter.md
# step_arbiter

Round-robin arbiter and sequencer that shares one step-driven pulse-counting state machine (single-bit `data_in` input, advanced one state per high cycle) among several requesters. Each requester asks for a burst of N step pulses. The arbiter:
- grants one requester at a time,
- drives the shared `step_out` line for exactly N cycles,
- signals completion back to the granted requester.

It sits between the control logic of the requesting blocks and the shared step-counting FSM, whose step input is driven only by this block.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters (2–8).
- `LEN_W`, default 4: width of each burst-length field. Maximum burst is 2^LEN_W − 1.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, NUM_REQ: per-requester request level.
- `req_len`, input, NUM_REQ*LEN_W: packed burst lengths. Requester i uses bits [i*LEN_W +: LEN_W].
- `gnt`, output, NUM_REQ: one-hot grant, registered.
- `done`, output, NUM_REQ: one-cycle completion pulse to the granted requester, registered.
- `step_out`, output, 1: step pulse to the shared FSM's `data_in`, registered.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- **Reset values:** state = IDLE; `gnt`, `done`, `step_out`, `busy` = 0; length counter = 0; round-robin pointer = NUM_REQ−1, so requester 0 wins first.
- **States:** IDLE, ISSUE, GAP (only when the macro is enabled), DONE.
- **IDLE**
  - If any `req` bit is high, select the winner: the first asserted requester scanning upward from pointer+1, modulo NUM_REQ.
  - Latch the winner's `req_len` into the counter.
  - Set `gnt[winner]` = 1.
  - If the length is 0, go to DONE. Otherwise go to ISSUE.
  - If no `req` bit is high, stay in IDLE with all outputs 0.
- **ISSUE**
  - `step_out` = 1 and the counter decrements.
  - When the counter equals 1, the next state is DONE. Otherwise it is ISSUE, or GAP when the macro is enabled.
- **GAP:** `step_out` = 0, then return to ISSUE.
- **DONE**
  - `done[winner]` = 1 and `gnt` = 0.
  - The pointer updates to the winner.
  - Next state is IDLE.
- **Length:** latched once at grant. Changes to `req_len` during a burst are ignored.
- **Requests during a burst:** deasserting `req` mid-burst does not abort it; the burst completes and `done` still fires. New requests arriving during a burst wait for IDLE.
- **Request after done:** a requester must drop `req` in the cycle after `done`. A request still held is treated as a new request and arbitrated fairly against the others.
- **Counter width:** LEN_W, with no wrap. The ISSUE exit is taken at count 1, so the counter never underflows.
- **Pulse count:** exactly L `step_out` pulses per grant, and never more than one grant active.

## Timing
- A request seen in IDLE at the edge ending cycle 0 gives:
  - `gnt`/`busy` high from cycle 1,
  - `step_out` high in cycles 1..L (without the macro),
  - `done` in cycle L+1,
  - return to IDLE in cycle L+2.
- Back-to-back grants are separated by one DONE cycle plus one IDLE arbitration cycle.
- Zero-length burst: `gnt` high in cycle 1 with no `step_out`, `done` in cycle 2.
- Asynchronous reset mid-burst: all outputs clear immediately and the partial burst is lost. The downstream FSM is reset by the same `reset`.

## Configuration
- **`STEP_ARB_GAP_EN` defined:** one GAP cycle is inserted between consecutive step pulses, so `step_out` toggles high/low.
  - A length-L burst occupies 2L−1 cycles.
  - `done` arrives in cycle 2L.
  - Use this when the downstream consumer needs discrete pulses.
- **Undefined:** pulses are contiguous and the GAP state is not generated.

## Structure
- **Shared package `step_arb_pkg`:** the state encoding (IDLE=2'b00, ISSUE=2'b01, GAP=2'b10, DONE=2'b11) and the default NUM_REQ/LEN_W constants.
- **Sub-module `rr_pick`:** a combinational round-robin selector with inputs `req` and `ptr`, and outputs one-hot `pick`, `pick_idx` and `any`.
- **Top-level FSM:** the state register, the length counter and the registered outputs.

## Test plan
- **Single request:** `req`=4'b0001, len0=3 → `gnt`=0001 in cycles 1–3, `step_out` high in cycles 1,2,3, `done`=0001 in cycle 4.
- **Round-robin fairness:** `req`=4'b1111 held, all lengths 1 → grant order 0,1,2,3,0, each `done` 3 cycles apart.
- **Zero length:** `req`=4'b0100, len2=0 → `gnt`=0100 for one cycle, no `step_out`, `done`=0100 in cycle 2.
- **Changes mid-burst:** during a len=5 burst, drop `req` and change `req_len` to 1 → still 5 pulses, then `done`.
- **Reset mid-burst:** `reset` high during ISSUE → `gnt`/`step_out`/`busy` are 0 asynchronously; after release, requester 0 wins first.
- **Gap mode:** with `STEP_ARB_GAP_EN`, len=3 → `step_out` pattern 1,0,1,0,1 over cycles 1–5, `done` in cycle 6.
